// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluator: scans OAM for sprites covering a latched line and packs
// matching addresses into a double-buffered slot array consumed by the sprite drawer.
module sprite_line_evaluator #(
    parameter int OAM_ADDR_SIZE     = 8,
    parameter int OAM_DATA_SIZE     = 32,
    parameter int SLOT_COUNT        = 32,
    parameter int SPRITE_HEIGHT     = 16,
    parameter int LINE_NUMBER_WIDTH = 10
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [LINE_NUMBER_WIDTH-1:0]            line_number,
    output logic [OAM_ADDR_SIZE-1:0]                oam_addr,
    input  logic [OAM_DATA_SIZE-1:0]                oam_data,
    output logic                                    busy,
    output logic                                    line_prepared,
    output logic [SLOT_COUNT-1:0][OAM_ADDR_SIZE:0]  slot_array,
    output logic [$clog2(SLOT_COUNT+1)-1:0]         slot_count,
    output logic                                    overflow
);
    localparam int CNT_W = $clog2(SLOT_COUNT + 1);
    localparam int IDX_W = $clog2(SLOT_COUNT);
    localparam logic [OAM_ADDR_SIZE-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, LAST, DONE} state_t;

    state_t                                 state, state_next;
    logic [LINE_NUMBER_WIDTH-1:0]           line_p0;
    logic                                   vld_p1;
    logic [OAM_ADDR_SIZE-1:0]               addr_p1;
    logic [SLOT_COUNT-1:0][OAM_ADDR_SIZE:0] back_slots;
    logic [CNT_W-1:0]                       back_count;
    logic                                   back_ovf;
    logic                                   hit, full, hit_full;
    logic                                   unused_oam;

    assign unused_oam = ^oam_data;

    // Compare in one extra bit so a sprite near the bottom never wraps onto low lines.
    function automatic logic sprite_match(input logic [OAM_DATA_SIZE-1:0] word,
                                          input logic [LINE_NUMBER_WIDTH-1:0] line);
        logic [LINE_NUMBER_WIDTH:0] line_ext;
        logic [LINE_NUMBER_WIDTH:0] y_ext;
        logic [LINE_NUMBER_WIDTH:0] h;
        line_ext = {1'b0, line};
        y_ext    = (LINE_NUMBER_WIDTH+1)'(word[19:10]);
        h        = word[30] ? (LINE_NUMBER_WIDTH+1)'(2 * SPRITE_HEIGHT)
                            : (LINE_NUMBER_WIDTH+1)'(SPRITE_HEIGHT);
        return word[31] && (line_ext >= y_ext) && ((line_ext - y_ext) < h);
    endfunction

    assign hit      = vld_p1 && (state == SCAN || state == LAST) && sprite_match(oam_data, line_p0);
    assign full     = (back_count == CNT_W'(SLOT_COUNT));
    assign hit_full = hit && full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: begin
                if (hit_full)                  state_next = DONE;
                else if (oam_addr == ADDR_MAX) state_next = LAST;
            end
            LAST:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: line latch and address issue; stage p1: RAM data meets its address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oam_addr      <= '0;
            busy          <= 1'b0;
            line_prepared <= 1'b0;
            line_p0       <= '0;
            vld_p1        <= 1'b0;
            addr_p1       <= '0;
            back_slots    <= '0;
            back_count    <= '0;
            back_ovf      <= 1'b0;
            slot_array    <= '0;
            slot_count    <= '0;
            overflow      <= 1'b0;
        end else begin
            line_prepared <= 1'b0;
            vld_p1        <= (state == SCAN);
            addr_p1       <= oam_addr;
            case (state)
                IDLE: if (start) begin
                    line_p0    <= line_number;
                    back_slots <= '0;
                    back_count <= '0;
                    back_ovf   <= 1'b0;
                    oam_addr   <= '0;
                    busy       <= 1'b1;
                end
                SCAN: if (oam_addr != ADDR_MAX) oam_addr <= oam_addr + 1'b1;
                DONE: begin
                    slot_array    <= back_slots;
                    slot_count    <= back_count;
                    overflow      <= back_ovf;
                    line_prepared <= 1'b1;
                    busy          <= 1'b0;
                end
                default: ;
            endcase
            if (hit && !full) begin
                back_slots[back_count[IDX_W-1:0]] <= {addr_p1, 1'b1};
                back_count <= back_count + 1'b1;
            end
            if (hit_full) back_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Scoreboard bench for sprite_line_evaluator: a behavioural OAM model predicts each line's
// slot array, count, overflow and completion latency; a monitor checks them on line_prepared.
module tb_sprite_line_evaluator;
    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [9:0]        line_number;
    logic [7:0]        oam_addr;
    logic [31:0]       oam_data;
    logic              busy;
    logic              line_prepared;
    logic [31:0][8:0]  slot_array;
    logic [5:0]        slot_count;
    logic              overflow;

    typedef struct {
        logic [31:0][8:0] slots;
        int               count;
        bit               ovf;
        int               lat;
        int               t0;
    } exp_t;

    logic [31:0] oam_mem [256];
    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          prepared_cnt = 0;

    sprite_line_evaluator dut (
        .clk(clk), .reset(reset), .start(start), .line_number(line_number),
        .oam_addr(oam_addr), .oam_data(oam_data), .busy(busy),
        .line_prepared(line_prepared), .slot_array(slot_array),
        .slot_count(slot_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        oam_data <= oam_mem[oam_addr];
    end

    function automatic logic [31:0] spr(input bit vis, input bit tall, input int y);
        logic [31:0] w;
        w = 32'd0;
        w[31] = vis;
        w[30] = tall;
        w[19:10] = y[9:0];
        return w;
    endfunction

    function automatic exp_t model(input int line);
        exp_t e;
        int y, h;
        e.slots = '0; e.count = 0; e.ovf = 0; e.lat = 258; e.t0 = 0;
        for (int a = 0; a < 256; a++) begin
            y = int'(oam_mem[a][19:10]);
            h = oam_mem[a][30] ? 32 : 16;
            if (oam_mem[a][31] && line >= y && (line - y) < h) begin
                if (e.count < 32) begin
                    e.slots[e.count] = {a[7:0], 1'b1};
                    e.count++;
                end else begin
                    e.ovf = 1;
                    e.lat = a + 3;
                    break;
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && line_prepared === 1'b1) begin
            prepared_cnt++;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_line_prepared at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (int'(slot_count) !== mon_e.count) begin
                    failures++;
                    $display("FAIL slot_count got %0d expected %0d", slot_count, mon_e.count);
                end
                checks++;
                if (overflow !== mon_e.ovf) begin
                    failures++;
                    $display("FAIL overflow got %0b expected %0b", overflow, mon_e.ovf);
                end
                checks++;
                if (slot_array !== mon_e.slots) begin
                    failures++;
                    $display("FAIL slot_array got %h expected %h", slot_array, mon_e.slots);
                end
                checks++;
                if ((cyc - mon_e.t0) !== mon_e.lat) begin
                    failures++;
                    $display("FAIL latency got %0d expected %0d", cyc - mon_e.t0, mon_e.lat);
                end
            end
        end
    end

    task automatic clear_oam();
        for (int a = 0; a < 256; a++) oam_mem[a] = 32'd0;
    endtask

    task automatic start_line(input int line);
        exp_t e;
        e = model(line);
        @(negedge clk);
        start = 1'b1;
        line_number = 10'(line);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.t0 = cyc;
        sb.push_back(e);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got %b expected 1", busy);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL done_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; line_number = '0;
        clear_oam();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (slot_array !== '0 || slot_count !== 6'd0 || overflow !== 1'b0 ||
                busy !== 1'b0 || oam_addr !== 8'd0 || line_prepared !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cnt=%0d ovf=%b busy=%b addr=%0d lp=%b expected all 0",
                         slot_count, overflow, busy, oam_addr, line_prepared);
            end
        end
    endtask

    task automatic test_single();
        clear_oam();
        oam_mem[5] = spr(1, 0, 100);
        oam_mem[6] = spr(0, 0, 100);
        start_line(110); wait_done(400);
        start_line(116); wait_done(400);
        start_line(100); wait_done(400);
    endtask

    task automatic test_tall();
        clear_oam();
        oam_mem[7] = spr(1, 1, 100);
        start_line(131); wait_done(400);
        start_line(132); wait_done(400);
        start_line(99);  wait_done(400);
    endtask

    task automatic test_nowrap();
        clear_oam();
        oam_mem[9] = spr(1, 0, 1020);
        start_line(3);    wait_done(400);
        start_line(1023); wait_done(400);
    endtask

    task automatic test_overflow();
        for (int a = 0; a < 256; a++) oam_mem[a] = spr(1, 0, 0);
        start_line(0);
        wait_done(400);
    endtask

    task automatic test_busy_ignore();
        int base;
        clear_oam();
        oam_mem[5] = spr(1, 0, 100);
        base = prepared_cnt;
        start_line(110);
        repeat (50) @(negedge clk);
        checks++;
        if (slot_count !== 6'd32 || overflow !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL front_stable_while_busy cnt=%0d ovf=%b busy=%b expected 32 1 1",
                     slot_count, overflow, busy);
        end
        start = 1'b1; line_number = 10'd116;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        repeat (300) @(negedge clk);
        checks++;
        if ((prepared_cnt - base) !== 1) begin
            failures++;
            $display("FAIL single_prepared got %0d expected 1", prepared_cnt - base);
        end
    endtask

    task automatic test_reset_midscan();
        int n;
        @(negedge clk);
        start = 1'b1; line_number = 10'd110;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (oam_addr !== 8'd100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (oam_addr !== 8'd100) begin
            failures++;
            $display("FAIL midscan_reach addr=%0d expected 100", oam_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || slot_array !== '0 || slot_count !== 6'd0 ||
            overflow !== 1'b0 || oam_addr !== 8'd0 || line_prepared !== 1'b0) begin
            failures++;
            $display("FAIL midscan_reset busy=%b cnt=%0d ovf=%b addr=%0d expected 0 0 0 0",
                     busy, slot_count, overflow, oam_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || slot_count !== 6'd0) begin
            failures++;
            $display("FAIL after_reset_idle busy=%b cnt=%0d expected 0 0", busy, slot_count);
        end
        start_line(110);
        wait_done(400);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 256; a++)
            oam_mem[a] = spr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 400));
        oam_mem[255] = spr(1, 0, 1015);
        for (int i = 0; i < 5; i++) begin
            start_line((i == 4) ? 1020 : $urandom_range(0, 420));
            wait_done(400);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tall();
        test_nowrap();
        test_overflow();
        test_busy_ignore();
        test_reset_midscan();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
